// File: rtl/convnet_pkg.sv
// Shared ConvNet accelerator definitions: width helper, lane slicing helper and
// default pixel geometry constants.
package convnet_pkg;

    localparam int DEF_NIN       = 3;
    localparam int DEF_BIT_WIDTH = 8;

    // Ceiling log2 for constant width computations; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

    // LSB position of lane k in a packed pixel vector.
    function automatic int lane_lsb(input int k, input int bw);
        return k * bw;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy counter and registered rdy (not full) and
// valid (not empty) flags; no write-to-read bypass.
module sync_fifo
    import convnet_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_rdy,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             push;
    logic             pop;

    assign push = wr_en && wr_rdy;
    assign pop  = rd_en && rd_valid;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    // Flags are computed from the next occupancy so they are registered yet
    // reflect the state after this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_rdy   <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            wr_rdy   <= count_nxt < CW'(DEPTH);
            rd_valid <= count_nxt != '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/input_layer_buffer.sv
// Elastic input stage: buffers raster-order pixels and tags the head pixel with
// row/column/end-of-frame. Define INPUT_LAYER_BUFFER_FRAME_CNT_EN for frame_count.
module input_layer_buffer
    import convnet_pkg::*;
#(
    parameter int Nin        = DEF_NIN,
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int IMG_WIDTH  = 5,
    parameter int IMG_HEIGHT = 5,
    parameter int FIFO_DEPTH = 8
) (
`ifdef INPUT_LAYER_BUFFER_FRAME_CNT_EN
    output logic [15:0]                  frame_count,
`endif
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         input_layer_valid,
    input  logic [Nin*BIT_WIDTH-1:0]     input_layer_data,
    output logic                         input_layer_rdy,
    output logic                         out_valid,
    output logic [Nin*BIT_WIDTH-1:0]     out_data,
    output logic [clog2(IMG_WIDTH)-1:0]  out_col,
    output logic [clog2(IMG_HEIGHT)-1:0] out_row,
    output logic                         out_last,
    input  logic                         out_rdy
);

    localparam int COL_W = clog2(IMG_WIDTH);
    localparam int ROW_W = clog2(IMG_HEIGHT);

    logic pop;
    logic col_end;
    logic row_end;

    sync_fifo #(
        .WIDTH (Nin * BIT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (input_layer_valid),
        .wr_data  (input_layer_data),
        .wr_rdy   (input_layer_rdy),
        .rd_en    (out_rdy),
        .rd_data  (out_data),
        .rd_valid (out_valid)
    );

    assign pop      = out_valid && out_rdy;
    assign col_end  = out_col == COL_W'(IMG_WIDTH - 1);
    assign row_end  = out_row == ROW_W'(IMG_HEIGHT - 1);
    assign out_last = out_valid && col_end && row_end;

    // Position follows the read side, so it always describes the head pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_col <= '0;
            out_row <= '0;
        end else if (pop) begin
            if (col_end) begin
                out_col <= '0;
                out_row <= row_end ? '0 : out_row + 1'b1;
            end else begin
                out_col <= out_col + 1'b1;
            end
        end
    end

`ifdef INPUT_LAYER_BUFFER_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            frame_count <= '0;
        else if (pop && out_last)
            frame_count <= frame_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_input_layer_buffer.sv
// Randomized bench for input_layer_buffer against a queue-based reference model.
module tb_input_layer_buffer;

    localparam int NIN = 3;
    localparam int BW  = 8;
    localparam int W   = 5;
    localparam int H   = 5;
    localparam int D   = 8;
    localparam int DW  = NIN * BW;
    localparam int FR  = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_rdy;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    out_col;
    logic [2:0]    out_row;
    logic          out_last;
    logic          out_rdy = 1'b0;
`ifdef INPUT_LAYER_BUFFER_FRAME_CNT_EN
    logic [15:0]   frame_count;
`endif

    input_layer_buffer #(
        .Nin(NIN), .BIT_WIDTH(BW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)
    ) dut (
`ifdef INPUT_LAYER_BUFFER_FRAME_CNT_EN
        .frame_count       (frame_count),
`endif
        .clk               (clk),
        .rst_n             (rst_n),
        .input_layer_valid (in_valid),
        .input_layer_data  (in_data),
        .input_layer_rdy   (in_rdy),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_col           (out_col),
        .out_row           (out_row),
        .out_last          (out_last),
        .out_rdy           (out_rdy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: pixels in flight, pops since reset, frames completed.
    logic [DW-1:0] q[$];
    bit            rdy_m    = 1'b0;
    int            pop_n    = 0;
    int            frames_m = 0;
    bit            model_ok = 1'b0;
    int            acc      = 0;
    int            last_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'($urandom);
    endfunction

    // One clock: drive, check at negedge, advance the model at the edge.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit ordy);
        bit push;
        bit pop;
        in_valid = v;
        in_data  = d;
        out_rdy  = ordy;
        @(negedge clk);
        if (model_ok) begin
            chk("rdy", in_rdy, rdy_m);
            chk("valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("data", out_data, q[0]);
                chk("col", out_col, pop_n % W);
                chk("row", out_row, (pop_n / W) % H);
                chk("last", out_last, (pop_n % FR) == FR - 1);
            end else begin
                chk("last_idle", out_last, 0);
            end
`ifdef INPUT_LAYER_BUFFER_FRAME_CNT_EN
            chk("frame_count", frame_count, frames_m % 65536);
`endif
        end
        if (rst_n && ordy && out_valid === 1'b1 && out_last === 1'b1) last_seen++;
        push = model_ok && rst_n && v && rdy_m;
        pop  = model_ok && rst_n && (q.size() != 0) && ordy;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            rdy_m    = 1'b0;
            pop_n    = 0;
            frames_m = 0;
            model_ok = 1'b1;
        end else begin
            if (pop) begin
                if ((pop_n % FR) == FR - 1) frames_m++;
                void'(q.pop_front());
                pop_n++;
            end
            if (push) begin
                q.push_back(d);
                acc++;
            end
            rdy_m = q.size() < D;
        end
        #1;
    endtask

    task automatic rst_cycle();
        rst_n = 1'b0;
        cycle(1'b0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] h_data;
        logic [2:0]    h_col;
        logic [2:0]    h_row;
        int            cyc;

        // Reset and a straight 25-pixel frame.
        rst_cycle();
        chk("rdy_in_reset", in_rdy, 0);
        chk("valid_in_reset", out_valid, 0);
        cycle(1'b0, '0, 1'b1);
        chk("rdy_rise", in_rdy, 1);
        last_seen = 0;
        for (int i = 0; i < FR; i++) cycle(1'b1, rnd(), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, rnd(), 1'b1);
        chk("last_once", last_seen, 1);
        chk("frame_pops", pop_n, FR);

        // Stalled downstream: only the buffer depth is accepted.
        acc = 0;
        for (int i = 0; i < 10; i++) cycle(1'b1, rnd(), 1'b0);
        chk("accepted", acc, D);
        chk("rdy_full", in_rdy, 0);
        cycle(1'b0, rnd(), 1'b1);
        chk("rdy_recover", in_rdy, 1);

        // Refill, then attempt a push together with a pop while full.
        cycle(1'b1, rnd(), 1'b0);
        chk("refull", in_rdy, 0);
        acc = 0;
        cycle(1'b1, rnd(), 1'b1);
        chk("no_push_full", acc, 0);
        chk("rdy_after_pop", in_rdy, 1);
        for (int i = 0; i < 10; i++) cycle(1'b0, rnd(), 1'b1);
        chk("drained", out_valid, 0);

        // Mid-frame reset with 4 pixels buffered.
        rst_cycle();
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, rnd(), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, rnd(), 1'b0);
        cycle(1'b0, rnd(), 1'b1);
        chk("four_buffered", q.size(), 4);
        rst_cycle();
        chk("rst_valid", out_valid, 0);
        chk("rst_rdy", in_rdy, 0);
        chk("rst_last", out_last, 0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, rnd(), 1'b0);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_col", out_col, 0);
        chk("post_rst_row", out_row, 0);

        // Head stays stable while downstream stalls.
        cycle(1'b1, rnd(), 1'b0);
        cycle(1'b1, rnd(), 1'b0);
        h_data = out_data;
        h_col  = out_col;
        h_row  = out_row;
        for (int i = 0; i < 20; i++) begin
            cycle($urandom_range(0, 1) == 1, rnd(), 1'b0);
            chk("stable_data", out_data, h_data);
            chk("stable_col", out_col, h_col);
            chk("stable_row", out_row, h_row);
        end

        // Random valid/ready over three frames.
        rst_cycle();
        acc = 0;
        last_seen = 0;
        cyc = 0;
        while (pop_n < 3 * FR && cyc < 3000) begin
            cycle(acc < 3 * FR && $urandom_range(0, 1) == 1, rnd(), $urandom_range(0, 2) != 0);
            cyc++;
        end
        chk("rand_pops", pop_n, 3 * FR);
        chk("rand_lasts", last_seen, 3);
`ifdef INPUT_LAYER_BUFFER_FRAME_CNT_EN
        chk("rand_frames", frame_count, 3);
`endif
        cycle(1'b0, rnd(), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/input_layer_buffer.md
# input_layer_buffer

Elastic input stage of the ConvNet accelerator that sits directly downstream of the stimulus/host interface. It accepts raster-order pixel vectors of `Nin` feature maps over a valid/ready handshake and buffers them in a synchronous FIFO. It presents them to the first convolution layer tagged with their row/column position and an end-of-frame flag, absorbing bursts and downstream stalls without losing pixels.

## Interface
- `Nin`, 3, input feature map count (lanes per pixel)
- `BIT_WIDTH`, 8, bits per lane
- `IMG_WIDTH`, 5, pixels per row
- `IMG_HEIGHT`, 5, rows per frame
- `FIFO_DEPTH`, 8, buffer entries; power of two, ≥2

- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  one clock; reset is synchronous and active-low
- `input_layer_valid`  in  1  upstream pixel valid
- `input_layer_data`  in  Nin*BIT_WIDTH  upstream pixel; lane k at [k*BIT_WIDTH +: BIT_WIDTH]
- `input_layer_rdy`  out  1  buffer can accept a pixel this cycle
- `out_valid`  out  1  head pixel valid
- `out_data`  out  Nin*BIT_WIDTH  head pixel
- `out_col`  out  clog2(IMG_WIDTH)  column of head pixel
- `out_row`  out  clog2(IMG_HEIGHT)  row of head pixel
- `out_last`  out  1  head pixel is the last pixel of a frame
- `out_rdy`  in  1  downstream accepts head pixel

## Operation
- Push when `input_layer_valid && input_layer_rdy`; pop when `out_valid && out_rdy`.
- Occupancy counter width clog2(FIFO_DEPTH)+1; pointers clog2(FIFO_DEPTH), wrap modulo FIFO_DEPTH.
- `input_layer_rdy` is registered: next value = (next occupancy < FIFO_DEPTH).
- `out_valid` = occupancy ≠ 0.
- No bypass. A pixel pushed into an empty buffer is not visible in the same cycle.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- Full: rdy is 0, so no push is possible. A pop while full reasserts rdy on the next cycle.
- Position tracking on the read side:
  - `out_col` increments per pop and wraps from IMG_WIDTH-1 to 0.
  - On that wrap, `out_row` increments; it wraps from IMG_HEIGHT-1 to 0.
- `out_last` = `out_valid && out_col==IMG_WIDTH-1 && out_row==IMG_HEIGHT-1`.
- Data ignored when valid is low. Upstream may drop valid at any time. Downstream may hold `out_rdy` low indefinitely; head data and tags stay stable.
- Reset (`rst_n` low at a clock edge), including mid-frame:
  - Pointers, occupancy, col and row go to 0.
  - All buffered pixels are discarded.
  - `input_layer_rdy`=0, `out_valid`=0, `out_last`=0, `out_col`=0, `out_row`=0.
  - `out_data` content is don't-care while `out_valid` is 0.

## Timing
- Push-to-visible latency: 1 cycle. A pixel pushed at edge N has `out_valid` high after edge N.
- First `input_layer_rdy`=1: the cycle after the first edge with `rst_n` high.
- Throughput: 1 pixel/cycle sustained when `out_rdy` stays high.
- Full-to-rdy recovery: 1 cycle after the pop edge.

## Configuration
- `INPUT_LAYER_BUFFER_FRAME_CNT_EN` defined:
  - Adds output `frame_count` (16 bits, reset 0).
  - Increments on each pop where `out_last` is high, wrapping at 2^16.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `convnet_pkg`: `clog2` function, lane-slice helper, default BIT_WIDTH/Nin constants.
- Sub-module `sync_fifo`: storage, pointers, occupancy and registered full/empty.
- `input_layer_buffer` adds the read-side position tracker, `out_last` and the optional frame counter.

## Test plan
- Reset then stream 25 pixels with `out_rdy`=1:
  - `input_layer_rdy` rises 1 cycle after reset release.
  - Outputs appear 1 cycle after each push, in order.
  - col/row sweep (0,0)…(4,4); `out_last` high only on pixel 25.
- `out_rdy`=0 while pushing 10 pixels:
  - Exactly 8 are accepted; rdy drops after the 8th.
  - Raising `out_rdy` for one pop restores rdy the next cycle; no data is lost or duplicated.
- Buffer full, push attempted with one simultaneous pop: no push occurs (rdy=0); occupancy goes 8→7.
- Random valid/ready toggling over 3 frames: output sequence matches input, `out_last` exactly 3 times, and `frame_count`=3 when the macro is on.
- Assert `rst_n` low after 13 pixels with 4 buffered:
  - Next cycle `out_valid`=0, `input_layer_rdy`=0.
  - After release the first output is tagged (0,0).
- Hold `out_rdy` low for 20 cycles with the buffer non-empty: `out_data`, `out_col`, `out_row` are stable every cycle.
